// File: rtl/seq_pattern_detector_pkg.sv
// Shared constants and helpers for the sequence pattern detector.
// Pure functions and localparams; no logic, so no latency.
// No flow control here.
package seq_pattern_detector_pkg;

  // Upper bounds for the generic helper arguments.
  localparam int PAT_MAX_W = 64;
  localparam int SYM_MAX_W = 16;

  // Width of the progress readout: clog2(seq_len), never below 1.
  function automatic int prog_w(input int seq_len);
    int w;
    w = $clog2(seq_len);
    return (w < 1) ? 1 : w;
  endfunction

  // All-ones saturation value for a counter of the given width.
  function automatic logic [63:0] cnt_max(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Symbol i of a flat pattern vector (symbol 0 in the low bits).
  function automatic logic [SYM_MAX_W-1:0] pat_sym(input logic [PAT_MAX_W-1:0] pat,
                                                   input int i, input int num_w);
    logic [PAT_MAX_W-1:0] mask;
    mask = (64'd1 << num_w) - 64'd1;
    return SYM_MAX_W'((pat >> (i * num_w)) & mask);
  endfunction

endpackage

// File: rtl/seq_pattern_detector_if.sv
// Symbol stream, pattern configuration and result bundle for the detector.
// Wires only; no latency.
// Valid-only input: the detector always accepts, so there is no ready.
interface seq_pattern_detector_if
  import seq_pattern_detector_pkg::*;
#(
  parameter int NUM_W   = 3,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 8
) ();

  localparam int PROG_W = prog_w(SEQ_LEN);

  logic                     in_valid;
  logic [NUM_W-1:0]         num;
  logic [SEQ_LEN*NUM_W-1:0] pattern;
  logic                     overlap;
  logic                     clear;
  logic                     hit;
  logic [CNT_W-1:0]         match_cnt;
  logic [PROG_W-1:0]        progress;

  // Stream source / observer side.
  modport master (
    output in_valid, num, pattern, overlap, clear,
    input  hit, match_cnt, progress
  );

  // Detector side.
  modport slave (
    input  in_valid, num, pattern, overlap, clear,
    output hit, match_cnt, progress
  );

endinterface

// File: rtl/seq_pattern_detector_prefix_match.sv
// Compares the history+new symbol window against every pattern prefix at once.
// Purely combinational; results are registered by the top level.
// No flow control; evaluated every cycle, used only on accepting edges.
module seq_prefix_match
  import seq_pattern_detector_pkg::*;
#(
  parameter int NUM_W   = 3,
  parameter int SEQ_LEN = 3,
  parameter int PROG_W  = 2
) (
  input  logic [(SEQ_LEN-1)*NUM_W-1:0] i_history,
  input  logic [NUM_W-1:0]             i_num,
  input  logic [PROG_W-1:0]            i_fill,
  input  logic [SEQ_LEN*NUM_W-1:0]     i_pattern,
  output logic                         o_match,
  output logic [PROG_W-1:0]            o_fill_nxt,
  output logic [PROG_W-1:0]            o_prog_nxt
);

  localparam logic [PROG_W-1:0] FILL_FULL = PROG_W'(SEQ_LEN - 1);

  logic [PAT_MAX_W-1:0] w_pat_ext;
  logic [NUM_W-1:0]     w_win [SEQ_LEN];
  logic [NUM_W-1:0]     w_pat [SEQ_LEN];
  logic [SEQ_LEN-1:1]   w_pre_ok;
  logic                 w_full;

  assign w_pat_ext = PAT_MAX_W'(i_pattern);

  // Window: history slot 0 is oldest, the incoming symbol is newest.
  for (genvar j = 0; j < SEQ_LEN - 1; j++) begin : g_win
    assign w_win[j] = i_history[j*NUM_W +: NUM_W];
  end
  assign w_win[SEQ_LEN-1] = i_num;

  for (genvar j = 0; j < SEQ_LEN; j++) begin : g_pat
    assign w_pat[j] = NUM_W'(pat_sym(w_pat_ext, j, NUM_W));
  end

  // Full-window compare plus, for each k, newest k symbols vs. pattern prefix of length k.
  always_comb begin
    w_full   = 1'b1;
    w_pre_ok = '1;
    for (int j = 0; j < SEQ_LEN; j++) begin
      if (w_win[j] != w_pat[j]) w_full = 1'b0;
    end
    for (int k = 1; k < SEQ_LEN; k++) begin
      for (int j = 0; j < k; j++) begin
        if (w_win[SEQ_LEN-k+j] != w_pat[j]) w_pre_ok[k] = 1'b0;
      end
    end
  end

  assign o_match    = w_full && (i_fill == FILL_FULL);
  assign o_fill_nxt = (i_fill >= FILL_FULL) ? FILL_FULL : i_fill + PROG_W'(1);

  // Longest matching prefix that fits inside the post-update fill (KMP-style recovery).
  always_comb begin
    o_prog_nxt = '0;
    for (int k = 1; k < SEQ_LEN; k++) begin
      if (w_pre_ok[k] && (k <= int'(o_fill_nxt))) o_prog_nxt = PROG_W'(k);
    end
  end

endmodule

// File: rtl/seq_pattern_detector.sv
// Monitors a symbol stream for a programmable SEQ_LEN-symbol pattern; counts hits.
// hit pulses the cycle after the final symbol is sampled; progress updates on the same edge.
// Never stalls the stream: every valid symbol is consumed on its edge.
module seq_pattern_detector
  import seq_pattern_detector_pkg::*;
#(
  parameter int NUM_W   = 3,
  parameter int SEQ_LEN = 3,
  parameter int CNT_W   = 8
) (
  input logic                  clk,
  input logic                  reset,
  seq_pattern_detector_if.slave bus
);

  localparam int               PROG_W  = prog_w(SEQ_LEN);
  localparam int               HIST_W  = (SEQ_LEN - 1) * NUM_W;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(cnt_max(CNT_W));

  logic [HIST_W-1:0] r_hist;
  logic [PROG_W-1:0] r_fill;
  logic [PROG_W-1:0] r_prog;
  logic              r_hit;
  logic [CNT_W-1:0]  r_cnt;

  logic [HIST_W-1:0] w_hist_nxt;
  logic              w_match;
  logic [PROG_W-1:0] w_fill_nxt;
  logic [PROG_W-1:0] w_prog_nxt;

  seq_prefix_match #(
    .NUM_W   (NUM_W),
    .SEQ_LEN (SEQ_LEN),
    .PROG_W  (PROG_W)
  ) u_prefix (
    .i_history  (r_hist),
    .i_num      (bus.num),
    .i_fill     (r_fill),
    .i_pattern  (bus.pattern),
    .o_match    (w_match),
    .o_fill_nxt (w_fill_nxt),
    .o_prog_nxt (w_prog_nxt)
  );

  // Drop the oldest symbol, append the new one at the top.
  if (SEQ_LEN == 2) begin : g_shift_one
    assign w_hist_nxt = bus.num;
  end else begin : g_shift_many
    assign w_hist_nxt = {bus.num, r_hist[HIST_W-1:NUM_W]};
  end

  // History, fill, progress and hit pulse; bubbles hold everything but hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_hist <= '0;
      r_fill <= '0;
      r_prog <= '0;
      r_hit  <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      if (bus.in_valid) begin
        r_hist <= w_hist_nxt;
        r_hit  <= w_match;
        if (w_match && !bus.overlap) begin
          r_fill <= '0;
          r_prog <= '0;
        end else begin
          r_fill <= w_fill_nxt;
          r_prog <= w_prog_nxt;
        end
      end
    end
  end

  // Saturating hit counter; clear beats a coincident increment.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= '0;
    end else if (bus.clear) begin
      r_cnt <= '0;
    end else if (bus.in_valid && w_match && (r_cnt != CNT_MAX)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign bus.hit       = r_hit;
  assign bus.match_cnt = r_cnt;
  assign bus.progress  = r_prog;

endmodule
